// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry holding register per functional unit, round-robin
// grant of one held result per cycle onto a registered common data bus.
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   flush_in             drop all held and in-flight results
//   req_valid_in[i]      unit i presents a result
//   req_rob_ix_in        unit i ROB index at [i*PTR_SIZE +: PTR_SIZE]
//   req_value_in         unit i value at [i*32 +: 32]
//   req_dest_in          unit i dest/offset at [i*32 +: 32]
//   req_ready_out[i]     unit i holding register accepts this cycle
//   cdb_valid_out        registered broadcast valid
//   cdb_rob_ix_out       broadcast ROB index
//   cdb_value_out        broadcast value
//   cdb_dest_out         broadcast dest/offset
//   cdb_src_out          winning unit index
//   busy_out             any holding register occupied
module cdb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int PTR_SIZE = 3,
  parameter int SRC_W    = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        flush_in,
  input  logic [NUM_REQ-1:0]          req_valid_in,
  input  logic [NUM_REQ*PTR_SIZE-1:0] req_rob_ix_in,
  input  logic [NUM_REQ*32-1:0]       req_value_in,
  input  logic [NUM_REQ*32-1:0]       req_dest_in,
  output logic [NUM_REQ-1:0]          req_ready_out,
  output logic                        cdb_valid_out,
  output logic [PTR_SIZE-1:0]         cdb_rob_ix_out,
  output logic signed [31:0]          cdb_value_out,
  output logic signed [31:0]          cdb_dest_out,
  output logic [SRC_W-1:0]            cdb_src_out,
  output logic                        busy_out
);

  typedef struct packed {
    logic [PTR_SIZE-1:0] ix;
    logic [31:0]         val;
    logic [31:0]         dest;
  } ent_t;

  ent_t               hold_q [NUM_REQ];
  ent_t               req_ent [NUM_REQ];
  logic [NUM_REQ-1:0] hold_v;
  logic [SRC_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  logic               gnt_any;
  logic [SRC_W-1:0]   gnt_ix;
  logic [SRC_W-1:0]   rr_nxt;
  ent_t               gnt_ent;
  int                 idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ent[i].ix   = req_rob_ix_in[i*PTR_SIZE +: PTR_SIZE];
      req_ent[i].val  = req_value_in[i*32 +: 32];
      req_ent[i].dest = req_dest_in[i*32 +: 32];
    end
  end

  // Scan from rr_ptr upward with wrap; first occupied holder wins.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_ix  = '0;
    gnt_ent = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == idx && hold_v[j] && !gnt_any) begin
          gnt_any  = 1'b1;
          gnt_ix   = SRC_W'(j);
          gnt_ent  = hold_q[j];
          grant[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_nxt = gnt_ix + 1'b1;
    if (int'(gnt_ix) == NUM_REQ - 1)
      rr_nxt = '0;
  end

  // A granted holder drains this edge, so it can refill in the same cycle.
  assign req_ready_out = {NUM_REQ{!flush_in}} & (~hold_v | grant);
  assign accept        = req_valid_in & req_ready_out;
  assign busy_out      = |hold_v;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_v         <= '0;
      rr_ptr         <= '0;
      cdb_valid_out  <= 1'b0;
      cdb_rob_ix_out <= '0;
      cdb_value_out  <= '0;
      cdb_dest_out   <= '0;
      cdb_src_out    <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        hold_q[i] <= '0;
    end else if (flush_in) begin
      hold_v        <= '0;
      cdb_valid_out <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          hold_q[i] <= req_ent[i];
          hold_v[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
      if (gnt_any) begin
        cdb_valid_out  <= 1'b1;
        cdb_rob_ix_out <= gnt_ent.ix;
        cdb_value_out  <= gnt_ent.val;
        cdb_dest_out   <= gnt_ent.dest;
        cdb_src_out    <= gnt_ix;
        rr_ptr         <= rr_nxt;
      end else begin
        cdb_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a broadcast scoreboard
// checked by an independent CDB monitor.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic [2:0]  req_valid_in;
  logic [8:0]  req_rob_ix_in;
  logic [95:0] req_value_in;
  logic [95:0] req_dest_in;
  logic [2:0]  req_ready_out;
  logic        cdb_valid_out;
  logic [2:0]  cdb_rob_ix_out;
  logic [31:0] cdb_value_out;
  logic [31:0] cdb_dest_out;
  logic [1:0]  cdb_src_out;
  logic        busy_out;

  cdb_arbiter #(
    .NUM_REQ (3),
    .PTR_SIZE(3),
    .SRC_W   (2)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .flush_in      (flush_in),
    .req_valid_in  (req_valid_in),
    .req_rob_ix_in (req_rob_ix_in),
    .req_value_in  (req_value_in),
    .req_dest_in   (req_dest_in),
    .req_ready_out (req_ready_out),
    .cdb_valid_out (cdb_valid_out),
    .cdb_rob_ix_out(cdb_rob_ix_out),
    .cdb_value_out (cdb_value_out),
    .cdb_dest_out  (cdb_dest_out),
    .cdb_src_out   (cdb_src_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  src;
    logic [2:0]  ix;
    logic [31:0] val;
    logic [31:0] dest;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] ix,
                         input logic [31:0] v, input logic [31:0] d);
    req_rob_ix_in[i*3 +: 3] = ix;
    req_value_in[i*32 +: 32] = v;
    req_dest_in[i*32 +: 32]  = d;
  endtask

  task automatic expect_b(input int c, input int src, input int ix,
                          input logic [31:0] v, input logic [31:0] d);
    exp_t e;
    e.cyc  = c;
    e.src  = 2'(src);
    e.ix   = 3'(ix);
    e.val  = v;
    e.dest = d;
    q.push_back(e);
  endtask

  // Hold valid on each masked unit; advance its payload after acceptance.
  task automatic run_stream(input logic [2:0] mask, input int ncyc,
                            input logic [31:0] vb0, input logic [31:0] vb1,
                            input logic [31:0] vb2);
    int          k[3];
    logic [31:0] vb[3];
    logic [31:0] v;
    vb = '{vb0, vb1, vb2};
    k  = '{0, 0, 0};
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 3; i++) begin
        v = vb[i] + k[i];
        set_req(i, 3'((i + k[i]) & 7), v, ~v);
      end
      req_valid_in = mask;
      @(negedge clk_in);
      for (int i = 0; i < 3; i++)
        if (mask[i] && req_ready_out[i])
          k[i]++;
      step();
    end
    req_valid_in = '0;
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (cdb_valid_out === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bcast: got src %0d val %0h at cycle %0d, required none",
                 cdb_src_out, cdb_value_out, cyc);
      end else begin
        e = q.pop_front();
        chk("bcast_cycle", cyc, e.cyc);
        chk("bcast_src", 32'(cdb_src_out), 32'(e.src));
        chk("bcast_ix", 32'(cdb_rob_ix_out), 32'(e.ix));
        chk("bcast_val", cdb_value_out, e.val);
        chk("bcast_dest", cdb_dest_out, e.dest);
      end
    end
  end

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int          n;
    int          ii;
    int          kk;
    logic [31:0] v;
    logic [31:0] vb[3];

    rst_in        = 1'b1;
    flush_in      = 1'b0;
    req_valid_in  = '0;
    req_rob_ix_in = '0;
    req_value_in  = '0;
    req_dest_in   = '0;
    step();
    step();
    rst_in = 1'b0;

    @(negedge clk_in);
    chk("rst_cdb_valid", 32'(cdb_valid_out), 0);
    chk("rst_cdb_ix", 32'(cdb_rob_ix_out), 0);
    chk("rst_cdb_val", cdb_value_out, 0);
    chk("rst_cdb_dest", cdb_dest_out, 0);
    chk("rst_cdb_src", 32'(cdb_src_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_ready", 32'(req_ready_out), 32'h7);
    step();

    // single result from unit 0
    n = cyc;
    set_req(0, 3'd3, 32'h2A, 32'h0);
    req_valid_in = 3'b001;
    expect_b(n + 2, 0, 3, 32'h2A, 32'h0);
    step();
    req_valid_in = '0;
    idle(4);

    // all three in the same cycle, fresh round-robin pointer
    do_reset();
    n = cyc;
    set_req(0, 3'd1, 32'h100, 32'h10);
    set_req(1, 3'd2, 32'h200, 32'h20);
    set_req(2, 3'd4, 32'h300, 32'h30);
    req_valid_in = 3'b111;
    expect_b(n + 2, 0, 1, 32'h100, 32'h10);
    expect_b(n + 3, 1, 2, 32'h200, 32'h20);
    expect_b(n + 4, 2, 4, 32'h300, 32'h30);
    step();
    req_valid_in = '0;
    @(negedge clk_in);
    chk("t2_ready_c1", 32'(req_ready_out), 32'h1);
    chk("t2_busy_c1", 32'(busy_out), 1);
    step();
    @(negedge clk_in);
    chk("t2_ready_c2", 32'(req_ready_out), 32'h3);
    step();
    @(negedge clk_in);
    chk("t2_ready_c3", 32'(req_ready_out), 32'h7);
    chk("t2_busy_c3", 32'(busy_out), 1);
    step();
    @(negedge clk_in);
    chk("t2_busy_c4", 32'(busy_out), 0);
    idle(3);

    // full contention for 30 cycles: strict 0,1,2 rotation
    vb = '{32'h1000, 32'h2000, 32'h3000};
    n  = cyc;
    for (int j = 0; j < 32; j++) begin
      ii = j % 3;
      kk = j / 3;
      v  = vb[ii] + kk;
      expect_b(n + 2 + j, ii, (ii + kk) & 7, v, ~v);
    end
    run_stream(3'b111, 30, vb[0], vb[1], vb[2]);
    idle(6);

    // unit 1 streaming alone at one per cycle
    n = cyc;
    for (int j = 0; j < 8; j++)
      expect_b(n + 2 + j, 1, (1 + j) & 7, 32'(1 + j), ~32'(1 + j));
    run_stream(3'b010, 8, 32'h0, 32'h1, 32'h0);
    idle(4);

    // fill all holds, then flush before anything is broadcast
    set_req(0, 3'd7, 32'hAAAA, 32'h1);
    set_req(1, 3'd6, 32'hBBBB, 32'h2);
    set_req(2, 3'd5, 32'hCCCC, 32'h3);
    req_valid_in = 3'b111;
    step();
    flush_in = 1'b1;
    @(negedge clk_in);
    chk("t5_ready_flush", 32'(req_ready_out), 0);
    chk("t5_busy_full", 32'(busy_out), 1);
    step();
    flush_in     = 1'b0;
    req_valid_in = '0;
    @(negedge clk_in);
    chk("t5_busy_after", 32'(busy_out), 0);
    chk("t5_ready_after", 32'(req_ready_out), 32'h7);
    idle(3);

    // reset mid-stream; pointer was left at 2 by the unit-1 stream
    n = cyc;
    expect_b(n + 2, 2, 2, 32'h6000, ~32'h6000);
    expect_b(n + 3, 0, 0, 32'h4000, ~32'h4000);
    expect_b(n + 4, 1, 1, 32'h5000, ~32'h5000);
    run_stream(3'b111, 4, 32'h4000, 32'h5000, 32'h6000);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    n = cyc;
    set_req(1, 3'd5, 32'h77, 32'h11);
    set_req(2, 3'd6, 32'h88, 32'h22);
    req_valid_in = 3'b110;
    expect_b(n + 2, 1, 5, 32'h77, 32'h11);
    expect_b(n + 3, 2, 6, 32'h88, 32'h22);
    @(negedge clk_in);
    chk("t6_cdb_valid", 32'(cdb_valid_out), 0);
    chk("t6_cdb_ix", 32'(cdb_rob_ix_out), 0);
    chk("t6_cdb_val", cdb_value_out, 0);
    chk("t6_cdb_dest", cdb_dest_out, 0);
    chk("t6_cdb_src", 32'(cdb_src_out), 0);
    chk("t6_busy", 32'(busy_out), 0);
    chk("t6_ready", 32'(req_ready_out), 32'h7);
    step();
    req_valid_in = '0;
    idle(6);

    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
